rowbuf_scanout: RTL and testbench

ROWBUF_SCANOUT -- requirements
Module: rowbuf_scanout

---
 rtl/rowbuf_scanout_pkg.sv | 21 ++
 rtl/rowbuf_scanout_if.sv | 26 ++
 rtl/rowbuf_scanout_up_counter.sv | 25 ++
 rtl/rowbuf_scanout.sv | 94 +++++++++
 tb/tb_rowbuf_scanout.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/rowbuf_scanout_pkg.sv
// Shared PPU types and constants for the row-buffer scan-out path.
package rowbuf_scanout_pkg;

    localparam int ROW_PIXELS_DEF = 320;
    localparam int H_SCALE_DEF    = 2;

    typedef struct packed {
        logic [1:0] source;
        logic [3:0] palette;
        logic [3:0] color;
    } pix_word_t;

    typedef logic [23:0] rgb888_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } scan_state_e;

endpackage

// File: rtl/rowbuf_scanout_if.sv
// Row-buffer / palette RAM read ports and pixel output stream of the scan-out block.
interface rowbuf_scanout_if;
    import rowbuf_scanout_pkg::*;

    logic        line_start;
    logic [8:0]  rowram_rdaddr;
    pix_word_t   rowram_rddata;
    logic [9:0]  palram_rdaddr;
    rgb888_t     palram_rddata;
    rgb888_t     pix_rgb;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic        line_done;
    logic        busy;

    modport master (
        output line_start, rowram_rddata, palram_rddata,
        input  rowram_rdaddr, palram_rdaddr, pix_rgb, pix_valid, pix_x, line_done, busy
    );

    modport slave (
        input  line_start, rowram_rddata, palram_rddata,
        output rowram_rdaddr, palram_rdaddr, pix_rgb, pix_valid, pix_x, line_done, busy
    );

endinterface

// File: rtl/rowbuf_scanout_up_counter.sv
// Saturating up counter with synchronous clear; holds at MAX instead of wrapping.
module up_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MAX   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rowbuf_scanout.sv
// Scans one row buffer out through the palette RAM, optionally doubling each
// pixel horizontally, with a 3-stage valid/column pipeline matching RAM latency.
module rowbuf_scanout
    import rowbuf_scanout_pkg::*;
#(
    parameter int ROW_PIXELS = ROW_PIXELS_DEF,
    parameter int H_SCALE    = H_SCALE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    rowbuf_scanout_if.slave  bus
);

    localparam int         N     = ROW_PIXELS * H_SCALE;
    localparam int         SHIFT = (H_SCALE == 2) ? 1 : 0;
    localparam logic [9:0] LAST  = 10'(N - 1);

    scan_state_e state, state_nxt;
    logic [9:0]  rd_cnt;
    logic        rd_active, cnt_clear, busy;
    logic        v1, v2;
    logic [9:0]  x1, x2;
    logic        pix_valid_q, line_done_q;
    logic [9:0]  pix_x_q;
    rgb888_t     pix_rgb_q;

    up_counter #(
        .WIDTH (10),
        .MAX   (LAST)
    ) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (rd_active),
        .count  (rd_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.line_start)  state_nxt = ST_SCAN;
            ST_SCAN:  if (rd_cnt == LAST)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (line_done_q)     state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        rd_active = (state == ST_SCAN);
        cnt_clear = (state == ST_IDLE);
    end

    // Address is forced to 0 outside SCAN so it is already 0 on the first IDLE cycle.
    assign bus.rowram_rdaddr = rd_active ? 9'(rd_cnt >> SHIFT) : '0;
    assign bus.palram_rdaddr = bus.rowram_rddata;

    // Stage 1 aligns with rowram data, stage 2 with palram data, stage 3 is the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1          <= 1'b0;
            v2          <= 1'b0;
            x1          <= '0;
            x2          <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_rgb_q   <= '0;
            line_done_q <= 1'b0;
        end else begin
            v1          <= rd_active;
            x1          <= rd_active ? rd_cnt : '0;
            v2          <= v1;
            x2          <= x1;
            pix_valid_q <= v2;
            pix_x_q     <= v2 ? x2 : '0;
            pix_rgb_q   <= v2 ? bus.palram_rddata : '0;
            line_done_q <= (state == ST_DRAIN) && pix_valid_q && !v2;
        end
    end

    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = pix_x_q;
    assign bus.pix_rgb   = pix_rgb_q;
    assign bus.line_done = line_done_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_rowbuf_scanout.sv
// Bench for rowbuf_scanout: default build (320 x2) and a 4-pixel x1 build,
// checked every cycle against a timeline model plus a table of hand vectors.
module tb_rowbuf_scanout;
    import rowbuf_scanout_pkg::*;

    logic clk;
    logic rst;

    rowbuf_scanout_if if_a ();
    rowbuf_scanout_if if_b ();

    rowbuf_scanout u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    rowbuf_scanout #(
        .ROW_PIXELS (4),
        .H_SCALE    (1)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // RAM contents: row word and palette entry chosen by mode.
    int         row_mode = 0;
    int         pal_mode = 0;
    logic [9:0] rand_row [512];

    function automatic logic [9:0] row_word(input logic [8:0] a);
        case (row_mode)
            0:       return {1'b0, a};
            1:       return 10'd0;
            default: return rand_row[a];
        endcase
    endfunction

    function automatic logic [23:0] pal_word(input logic [9:0] a);
        case (pal_mode)
            0:       return {14'b0, a};
            1:       return (a == 10'd0) ? 24'h102030 : {14'b0, a};
            default: return {a[7:0] ^ 8'h5a, 4'h0, a, 2'b11};
        endcase
    endfunction

    initial begin
        if_a.rowram_rddata = '0;
        if_a.palram_rddata = '0;
        if_b.rowram_rddata = '0;
        if_b.palram_rddata = '0;
    end

    always @(posedge clk) begin
        if_a.rowram_rddata <= pix_word_t'(row_word(if_a.rowram_rdaddr));
        if_a.palram_rddata <= pal_word(if_a.palram_rdaddr);
        if_b.rowram_rddata <= pix_word_t'(row_word(if_b.rowram_rdaddr));
        if_b.palram_rddata <= pal_word(if_b.palram_rdaddr);
    end

    // Timeline model: an accepted line_start at cycle t0 fixes every output of
    // the row as a function of (cycle - t0); line_start is accepted when not busy.
    int cyc = 0;
    bit act [2];
    int t0  [2];

    task automatic model_step(input int d, input logic rst_v, input logic ls,
                              input logic bsy, input logic vld, input logic done,
                              input logic [9:0] x, input logic [23:0] rgb, input logic [8:0] addr);
        int n, h, rel;
        logic e_bsy, e_vld, e_done;
        logic [9:0]  e_x;
        logic [23:0] e_rgb;
        logic [8:0]  e_addr, a_addr;
        n = (d == 1) ? 4 : 640;
        h = (d == 1) ? 1 : 2;
        rel = cyc - t0[d];
        e_bsy = 1'b0; e_vld = 1'b0; e_done = 1'b0;
        e_x = '0; e_rgb = '0; e_addr = '0; a_addr = addr;
        if (!rst_v && act[d]) begin
            e_bsy  = (rel >= 1) && (rel <= n + 4);
            e_done = (rel == n + 4);
            if (rel >= 4 && rel <= n + 3) begin
                e_vld = 1'b1;
                e_x   = 10'(rel - 4);
                e_rgb = pal_word(row_word(9'((rel - 4) / h)));
            end
            if (rel >= 1 && rel <= n) e_addr = 9'((rel - 1) / h);
            else if (rel > n && rel <= n + 4) a_addr = '0;  // address is free during drain
        end
        check((d == 1) ? "cycle_b" : "cycle_a",
              {27'd0, bsy, vld, done, x, rgb, a_addr},
              {27'd0, e_bsy, e_vld, e_done, e_x, e_rgb, e_addr});
        if (rst_v) begin
            act[d] = 1'b0;
        end else if (ls && !e_bsy) begin
            act[d] = 1'b1;
            t0[d]  = cyc;
        end
    endtask

    always @(negedge clk) begin
        model_step(0, rst, if_a.line_start, if_a.busy, if_a.pix_valid, if_a.line_done,
                   if_a.pix_x, if_a.pix_rgb, if_a.rowram_rdaddr);
        model_step(1, rst, if_b.line_start, if_b.busy, if_b.pix_valid, if_b.line_done,
                   if_b.pix_x, if_b.pix_rgb, if_b.rowram_rdaddr);
        cyc++;
    end

    // Stimulus: drive just after the rising edge, sample on the falling edge.
    int cnt_valid, cnt_done, cnt_badbg;

    task automatic run_cycle(input logic la, input logic lb, input logic r);
        @(posedge clk);
        #1;
        if_a.line_start = la;
        if_b.line_start = lb;
        rst = r;
        @(negedge clk);
        if (if_a.pix_valid) cnt_valid++;
        if (if_a.line_done) cnt_done++;
        if (if_a.pix_valid && if_a.pix_rgb != 24'h102030) cnt_badbg++;
    endtask

    typedef struct {
        logic        ls;
        logic        busy;
        logic        valid;
        logic [9:0]  x;
        logic [23:0] rgb;
        logic        done;
    } vec_t;

    vec_t tbl [19];

    initial begin
        // Hand vectors for the 4-pixel x1 build: one row, a start coincident
        // with line_done (ignored), then a start the next cycle (accepted).
        for (int i = 0; i < 19; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 10'd0, 24'd0, 1'b0};
        tbl[0].ls = 1'b1;
        tbl[8].ls = 1'b1;
        tbl[9].ls = 1'b1;
        for (int i = 1; i <= 8; i++)  tbl[i].busy = 1'b1;
        for (int i = 10; i <= 17; i++) tbl[i].busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tbl[4 + k].valid  = 1'b1;
            tbl[4 + k].x      = 10'(k);
            tbl[4 + k].rgb    = 24'(k);
            tbl[13 + k].valid = 1'b1;
            tbl[13 + k].x     = 10'(k);
            tbl[13 + k].rgb   = 24'(k);
        end
        tbl[8].done  = 1'b1;
        tbl[17].done = 1'b1;

        for (int i = 0; i < 512; i++) rand_row[i] = 10'($urandom);

        rst = 1'b1;
        if_a.line_start = 1'b0;
        if_b.line_start = 1'b0;
        cnt_valid = 0; cnt_done = 0; cnt_badbg = 0;

        repeat (3) run_cycle(1'b0, 1'b0, 1'b1);
        repeat (2) run_cycle(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            run_cycle(1'b0, tbl[i].ls, 1'b0);
            check("table_b",
                  {27'd0, if_b.busy, if_b.pix_valid, if_b.line_done, if_b.pix_x, if_b.pix_rgb},
                  {27'd0, tbl[i].busy, tbl[i].valid, tbl[i].done, tbl[i].x, tbl[i].rgb});
        end

        // Default row with stray starts during SCAN, one at line_done, one just after.
        cnt_valid = 0; cnt_done = 0;
        for (int t = 0; t < 1300; t++)
            run_cycle(t == 0 || t == 5 || t == 300 || t == 644 || t == 645, 1'b0, 1'b0);
        check("two_rows_valid", 64'(cnt_valid), 64'd1280);
        check("two_rows_done",  64'(cnt_done),  64'd2);

        // Reset pulse in the middle of SCAN aborts the row.
        cnt_valid = 0; cnt_done = 0;
        for (int t = 0; t < 110; t++) run_cycle(t == 0, t == 0, t == 100);
        check("abort_done", 64'(cnt_done), 64'd0);
        cnt_valid = 0; cnt_done = 0;
        repeat (700) run_cycle(1'b0, 1'b0, 1'b0);
        check("after_abort_valid", 64'(cnt_valid), 64'd0);
        check("after_abort_done",  64'(cnt_done),  64'd0);
        for (int t = 0; t < 650; t++) run_cycle(t == 0, 1'b0, 1'b0);
        check("recover_valid", 64'(cnt_valid), 64'd640);
        check("recover_done",  64'(cnt_done),  64'd1);

        // All-zero row against a background palette entry.
        row_mode = 1; pal_mode = 1;
        cnt_valid = 0; cnt_badbg = 0;
        for (int t = 0; t < 650; t++) run_cycle(t == 0, t == 0, 1'b0);
        check("bg_valid", 64'(cnt_valid), 64'd640);
        check("bg_colour", 64'(cnt_badbg), 64'd0);

        // Random starts and occasional resets over random row contents.
        row_mode = 2; pal_mode = 2;
        for (int t = 0; t < 6000; t++)
            run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 999) == 0);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
